// File: rtl/spi_flash_seq.sv
// spi_flash_seq: SPI NOR flash command sequencer; PROGRAM support is built only when SPI_FLASH_SEQ_PROG_EN is defined
module spi_flash_seq #(
    parameter int LEN_W      = 8,
    parameter int CS_GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             done,
    output logic             err,
    output logic             cs_n,
    output logic             byte_req,
    output logic [7:0]       byte_tx,
    input  logic             byte_done,
    input  logic [7:0]       byte_rx
);
    localparam int GW = $clog2(CS_GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP_CYC - 1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);
    localparam logic [LEN_W:0] C1 = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] C2 = (LEN_W + 1)'(2);
    localparam logic [3:0] S_IDLE = 4'd0, S_ERR = 4'd1, S_CS_ON = 4'd2, S_OPC = 4'd3,
                           S_ADDR = 4'd4, S_DATA = 4'd5, S_FIN = 4'd6, S_GAP = 4'd7, S_POLL = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             sent_q, sent_d, byte_req_q, byte_req_d, rd_valid_q, rd_valid_d;
    logic [7:0]       byte_tx_q, byte_tx_d, rd_data_q, rd_data_d, opc, tx_val;
    logic             byte_st, wr_phase, issue, fin;

`ifdef SPI_FLASH_SEQ_PROG_EN
    // ph_q tracks the program sub-sequence: 1=WREN, 2=page write, 3=status poll
    logic [1:0] ph_q, ph_d;
    assign wr_phase = state_q == S_DATA && op_q == 2'd2;
    assign opc = op_q == 2'd0 ? 8'h9F : op_q == 2'd1 ? 8'h03 :
                 ph_q == 2'd1 ? 8'h06 : ph_q == 2'd2 ? 8'h02 : 8'h05;
`else
    assign wr_phase = 1'b0;
    assign opc = op_q == 2'd0 ? 8'h9F : 8'h03;
`endif

    assign byte_st = state_q inside {S_OPC, S_ADDR, S_DATA, S_POLL};
    assign tx_val = state_q == S_OPC ? opc :
                    state_q == S_ADDR ? (cnt_q == '0 ? addr_q[23:16] : cnt_q == C1 ? addr_q[15:8] : addr_q[7:0]) :
                    wr_phase ? wr_data : 8'h00;
    // One byte in flight at a time: issue only when nothing is outstanding
    assign issue = byte_st && !sent_q && (!wr_phase || wr_valid);
    assign fin = byte_st && sent_q && byte_done;

    assign cmd_ready = state_q == S_IDLE;
    assign done = state_q == S_FIN || state_q == S_ERR;
    assign err = state_q == S_ERR;
    assign cs_n = !(state_q inside {S_CS_ON, S_OPC, S_ADDR, S_DATA, S_POLL});
    assign wr_ready = wr_phase && !sent_q;
    assign byte_req = byte_req_q;
    assign byte_tx = byte_tx_q;
    assign rd_valid = rd_valid_q;
    assign rd_data = rd_data_q;

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        addr_d = addr_q;
        len_d = len_q;
        cnt_d = cnt_q;
        gap_d = gap_q;
        sent_d = issue ? 1'b1 : fin ? 1'b0 : sent_q;
        byte_req_d = issue;
        byte_tx_d = issue ? tx_val : byte_tx_q;
        rd_valid_d = fin && state_q == S_DATA && !wr_phase;
        rd_data_d = rd_valid_d ? byte_rx : rd_data_q;
`ifdef SPI_FLASH_SEQ_PROG_EN
        ph_d = ph_q;
`endif
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                op_d = cmd_op;
                addr_d = cmd_addr;
                len_d = cmd_len;
`ifdef SPI_FLASH_SEQ_PROG_EN
                state_d = cmd_op == 2'd3 ? S_ERR : S_CS_ON;
                ph_d = cmd_op == 2'd2 ? 2'd1 : 2'd0;
`else
                state_d = cmd_op[1] ? S_ERR : S_CS_ON;
`endif
            end
            S_ERR: state_d = S_IDLE;
            S_FIN: state_d = S_GAP;
            S_CS_ON: state_d = S_OPC;
            S_OPC: if (fin) begin
`ifdef SPI_FLASH_SEQ_PROG_EN
                if (ph_q == 2'd1) begin
                    state_d = S_GAP;
                    ph_d = 2'd2;
                end else if (ph_q == 2'd3) state_d = S_POLL;
                else
`endif
                if (op_q == 2'd0) begin
                    state_d = S_DATA;
                    cnt_d = C2;
                end else begin
                    state_d = S_ADDR;
                    cnt_d = '0;
                end
            end
            S_ADDR: if (fin) begin
                cnt_d = cnt_q == C2 ? {1'b0, len_q} : cnt_q + C1;
                state_d = cnt_q == C2 ? S_DATA : S_ADDR;
            end
            S_DATA: if (fin) begin
                cnt_d = cnt_q - C1;
                state_d = cnt_q != '0 ? S_DATA : wr_phase ? S_GAP : S_FIN;
`ifdef SPI_FLASH_SEQ_PROG_EN
                if (cnt_q == '0 && wr_phase) ph_d = 2'd3;
`endif
            end
`ifdef SPI_FLASH_SEQ_PROG_EN
            S_POLL: if (fin && !byte_rx[0]) begin
                state_d = S_FIN;
                ph_d = 2'd0;
            end
`endif
            S_GAP: begin
                gap_d = gap_q == GAP_LAST ? '0 : gap_q + GAP_ONE;
`ifdef SPI_FLASH_SEQ_PROG_EN
                if (gap_q == GAP_LAST) state_d = ph_q != 2'd0 ? S_CS_ON : S_IDLE;
`else
                if (gap_q == GAP_LAST) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GAP;
            op_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            gap_q <= '0;
            sent_q <= 1'b0;
            byte_req_q <= 1'b0;
            byte_tx_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q <= '0;
`ifdef SPI_FLASH_SEQ_PROG_EN
            ph_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            addr_q <= addr_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            gap_q <= gap_d;
            sent_q <= sent_d;
            byte_req_q <= byte_req_d;
            byte_tx_q <= byte_tx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q <= rd_data_d;
`ifdef SPI_FLASH_SEQ_PROG_EN
            ph_q <= ph_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: directed bench for spi_flash_seq with a byte-engine responder; PROGRAM path checked when SPI_FLASH_SEQ_PROG_EN is defined
module tb_spi_flash_seq;
    logic clk = 1'b0, rst_n;
    logic cmd_valid, cmd_ready, wr_valid, wr_ready, rd_valid, done, err, cs_n, byte_req, byte_done;
    logic [1:0] cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0] cmd_len, rd_data, wr_data, byte_tx, byte_rx;

    always #5 clk = ~clk;

    spi_flash_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .done(done), .err(err),
        .cs_n(cs_n), .byte_req(byte_req), .byte_tx(byte_tx), .byte_done(byte_done), .byte_rx(byte_rx)
    );

    int total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0, acc_cnt = 0, fall_cnt = 0, last_gap = 0, viol = 0, hi_run = 0, pend = 0;
    byte unsigned txq[$], rdq[$], rxq[$], wq[$];
    logic prev_cs = 1'b1, req_s, take_s;
    logic [7:0] tx_s;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input bit is_rd, input int n, input logic [127:0] v);
        int sz = is_rd ? rdq.size() : txq.size();
        chk({tag, "_count"}, sz, n);
        for (int i = 0; i < n; i++)
            chk(tag, i < sz ? int'(is_rd ? rdq[i] : txq[i]) : 999, int'(v[8*(n-1-i) +: 8]));
    endtask

    task automatic clear();
        txq.delete(); rdq.delete(); rxq.delete(); wq.delete();
        done_cnt = 0; err_cnt = 0; acc_cnt = 0; fall_cnt = 0; last_gap = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [23:0] a, input logic [7:0] l);
        int a0 = acc_cnt;
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
        while (acc_cnt == a0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1 cmd_valid = 1'b0;
        chk("accept", acc_cnt - a0, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk(tag, done_cnt, 1);
    endtask

    // Byte engine model plus output monitor
    initial forever begin
        @(negedge clk);
        req_s = byte_req; tx_s = byte_tx; take_s = wr_ready && wr_valid;
        if (byte_req && (pend > 0 || byte_done)) viol++;
        if (done && cmd_ready) viol++;
        if (rd_valid) rdq.push_back(rd_data);
        if (done) done_cnt++;
        if (done && err) err_cnt++;
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (prev_cs && !cs_n) begin
            fall_cnt++;
            last_gap = hi_run;
        end
        hi_run = cs_n ? hi_run + 1 : 0;
        prev_cs = cs_n;
        @(posedge clk); #1;
        byte_done = 1'b0;
        if (take_s && wq.size() > 0) wq.delete(0);
        wr_valid = wq.size() > 0;
        wr_data = wq.size() > 0 ? wq[0] : 8'h00;
        if (!rst_n) pend = 0;
        else if (req_s) begin
            txq.push_back(tx_s);
            pend = 2;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                byte_done = 1'b1;
                byte_rx = 8'h00;
                if (rxq.size() > 0) byte_rx = rxq.pop_front();
            end
        end
    end

    initial begin
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 0; byte_done = 0; byte_rx = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_strobes", {byte_req, rd_valid, done, err, wr_ready}, 0);
        chk("rst_byte_tx", byte_tx, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) chk("gap_ready_c3", cmd_ready, 0);
        @(negedge clk) chk("gap_ready_c4", cmd_ready, 1);
        chk("idle_cs_n", cs_n, 1);

        clear();
        rxq = {8'h00, 8'hEF, 8'h40, 8'h18};
        send(2'd0, 24'h0, 8'h0);
        wait_done("id_done", 200);
        chk_q("id_tx", 1'b0, 4, 128'h9F000000);
        chk_q("id_rd", 1'b1, 3, 128'hEF4018);
        chk("id_err", err_cnt, 0);
        chk("id_cs_windows", fall_cnt, 1);

        clear();
        rxq = {8'h00, 8'h00, 8'h00, 8'h00, 8'hAB};
        send(2'd1, 24'h123456, 8'h00);
        wait_done("rd0_done", 200);
        chk_q("rd0_tx", 1'b0, 5, 128'h0312345600);
        chk_q("rd0_rd", 1'b1, 1, 128'hAB);
        chk("rd0_cs_windows", fall_cnt, 1);

        clear();
        send(2'd1, 24'hABCDEF, 8'hFF);
        wait_done("rd256_done", 4000);
        chk("rd256_rd_count", rdq.size(), 256);
        chk("rd256_tx_count", txq.size(), 260);

        clear();
        begin
            int n = 0;
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 24'h000010; cmd_len = 8'h00;
            while (done_cnt < 2 && n < 400) begin
                @(posedge clk);
                n++;
            end
            #1 cmd_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        chk("b2b_done", done_cnt, 2);
        chk("b2b_accepts", acc_cnt, 2);
        chk("b2b_cs_windows", fall_cnt, 2);
        chk("b2b_cs_gap", last_gap, 6);

        clear();
        send(2'd3, 24'h0, 8'h0);
        chk("op3_done", done, 1);
        chk("op3_err", err, 1);
        @(posedge clk); #1;
        chk("op3_done_1cyc", done, 0);
        repeat (8) @(posedge clk);
        chk("op3_no_bytes", txq.size(), 0);
        chk("op3_cs_windows", fall_cnt, 0);

`ifndef SPI_FLASH_SEQ_PROG_EN
        clear();
        send(2'd2, 24'h000100, 8'h01);
        chk("prog_off_err", {done, err}, 2'b11);
        repeat (8) @(posedge clk);
        chk("prog_off_no_bytes", txq.size(), 0);
        chk("prog_off_cs_windows", fall_cnt, 0);
`endif

        clear();
        send(2'd1, 24'hABCDEF, 8'h03);
        begin
            int n = 0;
            while (txq.size() < 2 && n < 100) begin
                @(posedge clk); #2;
                n++;
            end
        end
        rst_n = 1'b0;
        #1;
        chk("midaddr_cs_n", cs_n, 1);
        chk("midaddr_done", done, 0);
        chk("midaddr_ready", cmd_ready, 0);
        repeat (6) @(posedge clk);
        chk("midaddr_no_done", done_cnt, 0);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) chk("midaddr_recover", cmd_ready, 1);

`ifdef SPI_FLASH_SEQ_PROG_EN
        clear();
        rxq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
        wq = {8'hA5, 8'h5A};
        send(2'd2, 24'h000100, 8'h01);
        wait_done("prog_done", 600);
        chk_q("prog_tx", 1'b0, 11, 128'h06020001_00A55A05_000000);
        chk("prog_err", err_cnt, 0);
        chk("prog_cs_windows", fall_cnt, 3);
        chk("prog_no_rd", rdq.size(), 0);
`endif

        chk("byte_rule_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_flash_seq.md
Name: spi_flash_seq

Overview:
- Command sequencer for the serial NOR flash attached to the PL SPI pins.
- Accepts high-level requests (read JEDEC ID, read data), expands them into opcode/address/data byte streams, and owns flash chip-select.
- Drives a byte-level SPI shift engine that handles sck/mosi/miso.
- Sits between the user logic and the byte engine.

Parameters:
- LEN_W, 8, width of cmd_len. Data byte count = cmd_len+1, so 1..2^LEN_W bytes.
- CS_GAP_CYC, 4, minimum clk cycles cs_n stays high after any deassertion before the next assertion (must be >=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  sequencer can accept a request
- cmd_op  in  2  0=READ_ID(0x9F), 1=READ(0x03), 2=PROGRAM(0x02), 3=reserved
- cmd_addr  in  24  flash byte address, sent MSB first
- cmd_len  in  LEN_W  data bytes minus one
- rd_data  out  8  received data byte
- rd_valid  out  1  one-cycle strobe qualifying rd_data
- wr_data  in  8  program data byte
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  sequencer needs the next program byte
- done  out  1  one-cycle strobe at request completion
- err  out  1  qualified by done; request rejected
- cs_n  out  1  flash chip select, active low
- byte_req  out  1  one-cycle strobe that starts a byte on the engine
- byte_tx  out  8  byte to shift out, valid with byte_req
- byte_done  in  1  engine finished a byte
- byte_rx  in  8  byte shifted in, valid with byte_done

Behaviour:
- Reset: clk and rst_n exactly as elsewhere in the codebase. One clock; reset is asynchronous and active-low.
  - rst_n low forces immediately: cs_n=1, cmd_ready=0, byte_req=0, byte_tx=0, rd_valid=0, rd_data=0, wr_ready=0, done=0, err=0. FSM goes to GAP with the gap counter cleared.
  - Reset mid-transfer abandons the transfer; the byte engine is reset by the same rst_n.
- Handshake: request accepted on the clk edge where cmd_valid & cmd_ready. cmd_op, cmd_addr and cmd_len are latched at that edge; cmd_ready drops the next cycle.
- cmd_ready=1 only in IDLE.
- Byte rule: exactly one byte outstanding. byte_req is never asserted while a byte is in flight; the next byte_req comes no earlier than the cycle after byte_done.
- States:
  - IDLE: cmd_ready=1. Accept -> CS_ON. Exception: op 3, or op 2 without the macro, -> ERR.
  - ERR: done=1, err=1 for one cycle, no SPI traffic -> IDLE.
  - CS_ON: cs_n goes low; one cycle setup -> OPC.
  - OPC: byte_req with the opcode, wait for byte_done. READ_ID -> DATA with count 3 (cmd_len ignored). READ/PROGRAM -> ADDR.
  - ADDR: three bytes cmd_addr[23:16], [15:8], [7:0] -> DATA.
  - DATA, read ops: byte_tx=0x00. Each byte_done produces rd_data=byte_rx and rd_valid=1 on the next cycle.
  - DATA, PROGRAM: see Optional Feature.
  - After the last byte: cs_n=1, done=1 (err=0) for one cycle -> GAP.
  - GAP: count CS_GAP_CYC cycles with cs_n=1 -> IDLE.
- Counters: data counter LEN_W+1 bits. No wrap; cmd_len=0xFF gives exactly 256 bytes. Address is not incremented by the sequencer; the flash auto-increments.
- Simultaneous events:
  - cmd_valid arriving during GAP is held off; cmd_ready rises on the first IDLE cycle.
  - done and cmd_ready are never high in the same cycle.
- byte_done while no byte is outstanding is ignored.

Optional Feature:
- Macro: SPI_FLASH_SEQ_PROG_EN.
- Defined: PROGRAM is supported.
  - Sequence: CS_ON, WREN 0x06, cs_n high, GAP; then CS_ON, 0x02, ADDR, DATA.
  - DATA: wr_ready=1 until wr_valid; each accepted byte is sent via byte_req, cmd_len+1 bytes total.
  - Then cs_n high, GAP, CS_ON, 0x05. Read status bytes (tx 0x00) with cs_n held low until byte_rx[0]==0; status bytes are not presented on rd_valid.
  - Then cs_n high and done -> GAP.
- Undefined: op 2 takes the ERR path (done+err, cs_n stays high). wr_ready tied 0. PROGRAM/WREN/POLL states not built.

Test Plan:
- After reset release: cs_n=1, cmd_ready=1 after CS_GAP_CYC=4 cycles, all strobes 0. Assert rst_n mid-ADDR -> cs_n=1 in the same cycle, no done.
- READ_ID, engine returns 0xEF,0x40,0x18 -> byte_tx sequence 0x9F,0x00,0x00,0x00. rd_data 0xEF,0x40,0x18 with 3 rd_valid. One done, err=0, cs_n low across all 4 bytes.
- READ addr 0x123456, len 0 -> tx 0x03,0x12,0x34,0x56,0x00, exactly 1 rd_valid. Len 0xFF -> exactly 256 rd_valid.
- Back-to-back READs with cmd_valid held high -> cs_n high for >=4 cycles between transfers; second request accepted only in IDLE.
- cmd_op=3 -> done=1, err=1 one cycle after accept, cs_n never low, no byte_req.
- With SPI_FLASH_SEQ_PROG_EN, PROGRAM addr 0x000100 len 1, data 0xA5,0x5A, status replies 0x01,0x01,0x00 -> tx 0x06 | 0x02,0x00,0x01,0x00,0xA5,0x5A | 0x05 plus 3 polls, 3 cs_n low windows, done after status 0x00. Without the macro -> err=1.
